mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch (IF) and the load/store unit (LSU) of the three-stage pipeline. Runs each access as a request/grant/response transaction with a watchdog timeout. Drives the stall signals that hold the pipeline while an access is outstanding. Discards in-flight fetch responses that a taken branch has made stale.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- TIMEOUT, 15, maximum cycles in REQ+WAIT before abort; legal range 2..255
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_valid or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch taken; kills the current/pending fetch
- if_valid  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetched word, valid with if_valid
- lsu_req  in  1  load/store request; held with all lsu_* fields until lsu_done
- lsu_we  in  1  1 = store
- lsu_be  in  DATA_W/8  byte enables
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  store data
- lsu_done  out  1  one-cycle LSU completion pulse
- lsu_rdata  out  DATA_W  load data, valid with lsu_done
- err  out  1  one-cycle pulse with a completion that ended by timeout
- mem_req, mem_we  out  1  memory request, write strobe
- mem_be  out  DATA_W/8;  mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  response valid; mem_rdata  in  DATA_W
- stall_if  out  1  hold the fetch stage
- stall_lsu  out  1  hold the execute stage
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT. Registers: owner (IF/LSU), last_owner, drop, timeout counter, latched request fields.
- IDLE arbitration:
  - Only LSU requesting: LSU wins.
  - Only IF requesting and if_flush low: IF wins.
  - Both requesting: IF wins if last_owner=LSU and if_flush low; otherwise LSU wins.
  - if_req with if_flush high in the same cycle is not accepted.
  - The winner's fields are latched, owner and last_owner are set, and the state goes to REQ.
- REQ: mem_req=1 with the latched fields. mem_we=0 and mem_be=all-ones for IF. On mem_gnt, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata, pulse the owner's completion next cycle, go to IDLE.
- Flush: if_flush while owner=IF in REQ/WAIT sets drop. The transaction still runs to mem_rvalid, since memory must drain it. if_valid is suppressed, and drop clears on return to IDLE. if_flush has no effect on LSU transactions.
- Timeout:
  - The counter clears on IDLE→REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT: go to IDLE, mem_req=0, pulse the owner's completion with rdata=0 and err=1. err is suppressed together with if_valid when drop is set.
  - A late mem_rvalid arriving in IDLE is ignored.
- stall_lsu = lsu_req & ~lsu_done.
- stall_if = (if_req & ~if_valid) | stall_lsu.
- Only one transaction is outstanding at any time.

## Timing
- Reset values: state=IDLE, owner=IF, last_owner=IF, drop=0, counter=0. All outputs 0, except stall_if/stall_lsu, which follow the inputs combinationally.
- Reset asserted mid-transaction aborts immediately, with no completion pulse.
- Minimum latency (request at cycle 0):
  - mem_req at cycle 1.
  - With gnt at 1 and rvalid at 2, the completion pulse is at cycle 3.
  - The next request can be sampled in IDLE at cycle 3, so mem_req is next asserted at cycle 4.
- Completion pulses, rdata and err are registered and last exactly one cycle. if_rdata and lsu_rdata hold their value until the next capture.
- mem_gnt or mem_rvalid in a state that does not expect it is ignored.
- Timeout with TIMEOUT=15: entering REQ at cycle 1 with no gnt gives abort on the cycle the counter hits 15, i.e. completion pulse at cycle 16.

## Test plan
- Single load: lsu_req, addr=0x100, gnt at cycle 1, rvalid at cycle 2 with rdata=0xDEADBEEF -> lsu_done=1 and lsu_rdata=0xDEADBEEF at cycle 3; stall_lsu high on cycles 0-2.
- Contention: if_req and lsu_req both asserted from reset -> LSU served first, then IF. Keeping both asserted alternates owners LSU, IF, LSU.
- Flush: IF in WAIT, if_flush pulsed, then rvalid -> no if_valid. A new fetch to 0x40 is accepted after IDLE and completes normally.
- Timeout: store issued, mem_gnt never asserted -> lsu_done=1 and err=1 exactly 15 cycles after REQ entry; mem_req drops; a late rvalid is ignored.
- Wait states: gnt delayed 3 cycles and rvalid delayed 4 -> mem_req held stable with fields unchanged; a single completion pulse.
- Reset mid-WAIT: rst_n low -> mem_req=0, busy=0, no completion pulse; normal operation after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bundle between arbiter and memory
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LSU arbiter for one shared memory port with timeout and fetch flush
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [DATA_W/8-1:0]   lsu_be,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    output logic                  lsu_done,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  err,
    output logic                  stall_if,
    output logic                  stall_lsu,
    output logic                  busy,
    mem_port_arbiter_if.master    mem
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              state, state_nxt;
    logic                owner_lsu, last_owner_lsu, drop;
    logic [7:0]          cnt;
    logic                addr_we_q;
    logic [BE_W-1:0]     be_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                if_pend, lsu_pend;
    logic                grant_if, grant_lsu;
    logic                done_ok, done_to, kill;

    // A requester whose completion pulse is visible this cycle is still holding
    // its old request; it must not be re-served from that stale level.
    assign lsu_pend = lsu_req & ~lsu_done;
    assign if_pend  = if_req & ~if_valid & ~if_flush;
    assign kill     = drop | if_flush;

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            S_IDLE: begin
                if (if_pend && (!lsu_pend || last_owner_lsu)) begin
                    grant_if  = 1'b1;
                    state_nxt = S_REQ;
                end else if (lsu_pend) begin
                    grant_lsu = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (cnt == CNT_LAST) begin
                    done_to   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (mem.mem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    done_ok   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    done_to   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            owner_lsu      <= 1'b0;
            last_owner_lsu <= 1'b0;
            drop           <= 1'b0;
            cnt            <= '0;
            addr_we_q      <= 1'b0;
            be_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            if_valid       <= 1'b0;
            if_rdata       <= '0;
            lsu_done       <= 1'b0;
            lsu_rdata      <= '0;
            err            <= 1'b0;
        end else begin
            state    <= state_nxt;
            if_valid <= 1'b0;
            lsu_done <= 1'b0;
            err      <= 1'b0;

            if (state != S_IDLE) begin
                cnt <= cnt + 8'd1;
            end

            if (grant_if) begin
                owner_lsu      <= 1'b0;
                last_owner_lsu <= 1'b0;
                addr_q         <= if_addr;
                addr_we_q      <= 1'b0;
                be_q           <= '1;
                wdata_q        <= '0;
                cnt            <= '0;
            end else if (grant_lsu) begin
                owner_lsu      <= 1'b1;
                last_owner_lsu <= 1'b1;
                addr_q         <= lsu_addr;
                addr_we_q      <= lsu_we;
                be_q           <= lsu_be;
                wdata_q        <= lsu_wdata;
                cnt            <= '0;
            end

            if (state_nxt == S_IDLE) begin
                drop <= 1'b0;
            end else if (state != S_IDLE && !owner_lsu && if_flush) begin
                drop <= 1'b1;
            end

            // A killed fetch still drains from memory but reports nothing.
            if (done_ok || done_to) begin
                if (owner_lsu) begin
                    lsu_done  <= 1'b1;
                    lsu_rdata <= done_ok ? mem.mem_rdata : '0;
                    err       <= done_to;
                end else if (!kill) begin
                    if_valid  <= 1'b1;
                    if_rdata  <= done_ok ? mem.mem_rdata : '0;
                    err       <= done_to;
                end
            end
        end
    end

    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = addr_we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign busy      = (state != S_IDLE);
    assign stall_lsu = lsu_req & ~lsu_done;
    assign stall_if  = (if_req & ~if_valid) | stall_lsu;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk, rst_n;
    logic          if_req, if_flush, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          lsu_req, lsu_we, lsu_done;
    logic [3:0]    lsu_be;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic          err, stall_if, stall_lsu, busy;

    int total = 0;
    int bad   = 0;
    int dcnt;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_be    (lsu_be),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .err       (err),
        .stall_if  (stall_if),
        .stall_lsu (stall_lsu),
        .busy      (busy),
        .mem       (mif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; if_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
        mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = '0;
        lsu_req = 1'b1;
        cyc();
        chk("rst_if_valid", if_valid, 0);
        chk("rst_lsu_done", lsu_done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_be", mif.mem_be, 0);
        chk("rst_stall_lsu", stall_lsu, 1);
        chk("rst_stall_if", stall_if, 1);
        lsu_req = 1'b0;
        #1;
        chk("rst_stall_lsu_lo", stall_lsu, 0);
        do_reset();

        // single load
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h100;
        #1;
        chk("ld_c0_stall_lsu", stall_lsu, 1);
        chk("ld_c0_mem_req", mif.mem_req, 0);
        cyc();
        chk("ld_c1_mem_req", mif.mem_req, 1);
        chk("ld_c1_addr", mif.mem_addr, 32'h100);
        chk("ld_c1_we", mif.mem_we, 0);
        chk("ld_c1_busy", busy, 1);
        mif.mem_gnt = 1;
        cyc();
        chk("ld_c2_mem_req", mif.mem_req, 0);
        chk("ld_c2_stall_lsu", stall_lsu, 1);
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'hDEADBEEF;
        cyc();
        mif.mem_rvalid = 0;
        chk("ld_c3_done", lsu_done, 1);
        chk("ld_c3_rdata", lsu_rdata, 32'hDEADBEEF);
        chk("ld_c3_err", err, 0);
        chk("ld_c3_stall_lsu", stall_lsu, 0);
        lsu_req = 0;
        cyc();
        chk("ld_c4_done", lsu_done, 0);
        chk("ld_c4_busy", busy, 0);

        // contention from reset: LSU, IF, LSU
        do_reset();
        if_req = 1; if_addr = 32'h200;
        lsu_req = 1; lsu_addr = 32'h300; lsu_we = 0; lsu_be = 4'hF;
        cyc();
        chk("ct_c1_addr", mif.mem_addr, 32'h300);
        chk("ct_c1_stall_if", stall_if, 1);
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h11111111;
        cyc();
        mif.mem_rvalid = 0;
        chk("ct_c3_lsu_done", lsu_done, 1);
        chk("ct_c3_lsu_rdata", lsu_rdata, 32'h11111111);
        chk("ct_c3_if_valid", if_valid, 0);
        chk("ct_c3_stall_if", stall_if, 1);
        cyc();
        chk("ct_c4_mem_req", mif.mem_req, 1);
        chk("ct_c4_addr", mif.mem_addr, 32'h200);
        chk("ct_c4_be", mif.mem_be, 4'hF);
        chk("ct_c4_lsu_done", lsu_done, 0);
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h22222222;
        cyc();
        mif.mem_rvalid = 0;
        chk("ct_c6_if_valid", if_valid, 1);
        chk("ct_c6_if_rdata", if_rdata, 32'h22222222);
        cyc();
        chk("ct_c7_mem_req", mif.mem_req, 1);
        chk("ct_c7_addr", mif.mem_addr, 32'h300);
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h33333333;
        cyc();
        mif.mem_rvalid = 0;
        chk("ct_c9_lsu_done", lsu_done, 1);
        chk("ct_c9_lsu_rdata", lsu_rdata, 32'h33333333);
        if_req = 0; lsu_req = 0;
        cyc();
        chk("ct_c10_busy", busy, 0);

        // flush of an in-flight fetch
        if_req = 1; if_addr = 32'h80;
        cyc();
        chk("fl_c1_addr", mif.mem_addr, 32'h80);
        mif.mem_gnt = 1;
        cyc();
        chk("fl_c2_busy", busy, 1);
        mif.mem_gnt = 0; if_flush = 1;
        cyc();
        if_flush = 0; if_addr = 32'h40;
        mif.mem_rvalid = 1; mif.mem_rdata = 32'h00000BAD;
        cyc();
        mif.mem_rvalid = 0;
        chk("fl_c4_if_valid", if_valid, 0);
        chk("fl_c4_err", err, 0);
        chk("fl_c4_busy", busy, 0);
        cyc();
        chk("fl_c5_mem_req", mif.mem_req, 1);
        chk("fl_c5_addr", mif.mem_addr, 32'h40);
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h0000600D;
        cyc();
        mif.mem_rvalid = 0;
        chk("fl_c7_if_valid", if_valid, 1);
        chk("fl_c7_if_rdata", if_rdata, 32'h0000600D);
        if_req = 0;
        cyc();

        // store that times out
        lsu_req = 1; lsu_we = 1; lsu_be = 4'b0011; lsu_addr = 32'h500; lsu_wdata = 32'hCAFEF00D;
        cyc();
        chk("to_c1_mem_req", mif.mem_req, 1);
        chk("to_c1_we", mif.mem_we, 1);
        chk("to_c1_be", mif.mem_be, 4'b0011);
        chk("to_c1_wdata", mif.mem_wdata, 32'hCAFEF00D);
        dcnt = 0;
        for (int k = 2; k <= 15; k++) begin
            cyc();
            if (lsu_done) dcnt++;
        end
        chk("to_early_done", dcnt, 0);
        chk("to_c15_mem_req", mif.mem_req, 1);
        cyc();
        chk("to_c16_done", lsu_done, 1);
        chk("to_c16_err", err, 1);
        chk("to_c16_rdata", lsu_rdata, 0);
        chk("to_c16_mem_req", mif.mem_req, 0);
        chk("to_c16_busy", busy, 0);
        lsu_req = 0; lsu_we = 0;
        mif.mem_rvalid = 1; mif.mem_rdata = 32'h0000FFFF;
        cyc();
        mif.mem_rvalid = 0;
        chk("to_late_done", lsu_done, 0);
        chk("to_late_err", err, 0);
        chk("to_late_rdata", lsu_rdata, 0);
        chk("to_late_busy", busy, 0);

        // wait states: gnt at cycle 4, rvalid at cycle 8
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h700;
        dcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            mif.mem_gnt = 0; mif.mem_rvalid = 0;
            chk($sformatf("ws_c%0d_mem_req", k), mif.mem_req, (k <= 4) ? 1 : 0);
            if (k <= 4) chk($sformatf("ws_c%0d_addr", k), mif.mem_addr, 32'h700);
            if (lsu_done) dcnt++;
            if (k == 9) begin
                chk("ws_c9_done", lsu_done, 1);
                chk("ws_c9_rdata", lsu_rdata, 32'h12345678);
                lsu_req = 0;
            end
            if (k == 4) mif.mem_gnt = 1;
            if (k == 8) begin
                mif.mem_rvalid = 1; mif.mem_rdata = 32'h12345678;
            end
        end
        chk("ws_done_count", dcnt, 1);

        // reset while in WAIT
        if_req = 1; if_addr = 32'h900;
        cyc();
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0;
        chk("rw_c2_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("rw_mem_req", mif.mem_req, 0);
        chk("rw_busy", busy, 0);
        cyc();
        chk("rw_if_valid", if_valid, 0);
        cyc();
        rst_n = 1;
        cyc();
        chk("rw_p1_mem_req", mif.mem_req, 1);
        chk("rw_p1_addr", mif.mem_addr, 32'h900);
        mif.mem_gnt = 1;
        cyc();
        mif.mem_gnt = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'h0000ABCD;
        cyc();
        mif.mem_rvalid = 0;
        chk("rw_p3_if_valid", if_valid, 1);
        chk("rw_p3_if_rdata", if_rdata, 32'h0000ABCD);
        if_req = 0;
        cyc();
        chk("rw_p4_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
